m_data_mem_unit: RTL and testbench
==================================

Name: m_data_mem_unit

Overview:
- M-stage data memory and store/load alignment unit of the 5-stage MIPS pipeline.
- Directly consumes the forwarded store word from the M-stage store-data forwarding mux (M_TrueStoreData).
- Places byte/half/word stores into a byte-enabled synchronous RAM.
- Reads, selects and extends load data, and registers it into the W stage (W_ReadData).

Parameters:
- ADDR_WIDTH, 12, word-address width; memory depth = 2^ADDR_WIDTH words of 32 bits (default 16 KiB).

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled only at posedge clk, reset==0 clears state.
- M_PC  in  32  PC of the instruction in M; used only by the optional write log.
- M_Addr  in  32  byte address (ALU result).
- M_MemWrite  in  1  store instruction in M.
- M_StoreType  in  2  00 sw, 01 sh, 10 sb, 11 reserved (treated as no store).
- M_MemRead  in  1  load instruction in M.
- M_LoadType  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others reserved (read as 0).
- M_TrueStoreData  in  32  forwarded store data; low byte/half is used for sb/sh.
- M_ByteEn  out  4  combinational byte-lane write enables, bit i = byte lane i.
- M_AlignErr  out  1  combinational; access is misaligned or out of range.
- W_ReadData  out  32  registered, extended load result for W.

Behaviour:
- Reset (reset==0 at posedge): every memory word <= 0; W_ReadData <= 0. Stores and loads in the same cycle are ignored.
- Byte addressing is little-endian: lane = M_Addr[1:0], word index = M_Addr[ADDR_WIDTH+1:2].
- Range check: the access is out of range if any M_Addr[31:ADDR_WIDTH+2] bit is 1.
- Alignment check:
  - sw or lw: misaligned if M_Addr[1:0] != 0.
  - sh, lh or lhu: misaligned if M_Addr[0] != 0.
  - Byte accesses are never misaligned.
- M_AlignErr = (M_MemWrite | M_MemRead) & (misaligned | out of range). It is 0 when neither strobe is set.
- M_ByteEn (all zero if M_MemWrite==0, M_AlignErr==1, or StoreType==11):
  - sw: 1111.
  - sh: 0011 if addr[1]==0, else 1100.
  - sb: one-hot 1<<addr[1:0].
- Write data lanes:
  - sw: M_TrueStoreData.
  - sh: {2{M_TrueStoreData[15:0]}}.
  - sb: {4{M_TrueStoreData[7:0]}}.
- Write: at posedge with reset==1, each lane whose M_ByteEn bit is set takes the new byte. Other lanes keep their old value.
- Load path:
  - The addressed word is read combinationally from the array in M.
  - Byte/half selection uses addr[1:0] / addr[1].
  - lh and lb sign-extend; lhu and lbu zero-extend.
  - The result is registered: W_ReadData is valid exactly 1 cycle after the load is in M, aligned with the M/W register.
- W_ReadData <= 0 when any of these hold:
  - M_MemRead==0.
  - M_AlignErr==1.
  - M_LoadType is reserved.
- Store followed by load to the same word in the next cycle: the load sees the updated bytes. Write-then-read ordering is guaranteed because the write commits at the earlier posedge.
- M_MemWrite and M_MemRead both set in the same cycle: the write commits. The load reads the pre-write word (old data).
- Unwritten memory reads 0 after reset.
- The highest word index wraps nowhere. Addresses beyond the range are rejected, never aliased.

Optional Feature:
- Macro: DM_WRITE_LOG_EN.
- Defined: on every committed write (any M_ByteEn bit set, reset==1), print a line at posedge with this format:
  - "%d@%h: *%h <= %h"
  - fields: $time, M_PC, {M_Addr[31:2],2'b00}, merged post-write word.
- Undefined: no display logic. M_PC is present but unused, and functional behaviour is identical.

Decomposition:
- Shared package (mem_pkg): StoreType encodings (ST_W, ST_H, ST_B), LoadType encodings (LD_W, LD_H, LD_HU, LD_B, LD_BU), and the default ADDR_WIDTH constant.
- One sub-module: m_load_extender. It is combinational and maps (word, addr[1:0], LoadType) to the extended 32-bit result. The top instantiates it before the W_ReadData register.

Test Plan:
- Reset, then lw at 0x0000_0010 -> W_ReadData = 0 one cycle later; M_AlignErr = 0.
- sw 0xDEADBEEF @0x10, then lb @0x13, lbu @0x13, lh @0x12, lhu @0x10 -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF, each one cycle after its load.
- sb 0x12345678 @0x21, then sh 0x0000ABCD @0x22, then lw @0x20 -> M_ByteEn 0010 then 1100; W_ReadData = 0xABCD7800.
- sw @0x0000_0006 and lh @0x0000_0003 -> M_AlignErr = 1, M_ByteEn = 0000, memory unchanged, W_ReadData = 0; sw to 0x0001_0000 (ADDR_WIDTH=12) is also rejected.
- Write 0x11111111 @0x40, assert reset (low) for one cycle with M_MemWrite=1 @0x40, then lw @0x40 -> W_ReadData = 0.
- With DM_WRITE_LOG_EN, sw 0xCAFEF00D @0x44 with PC 0x3008 -> one log line "…@00003008: *00000044 <= cafef00d"; without the macro, no output.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the M-stage data memory: store/load size codes and default geometry.
package mem_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_W   = 2'b00,
    ST_H   = 2'b01,
    ST_B   = 2'b10,
    ST_RSV = 2'b11
  } storeType_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } loadType_e;

endpackage

// File: rtl/m_load_extender.sv
// Combinational load selector: picks the byte/half out of a little-endian word and extends it.
module m_load_extender
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addrLow,
  input  logic [2:0]  loadType,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    shifted = word >> {addrLow, 3'b000};
    byteSel = shifted[7:0];
    halfSel = addrLow[1] ? word[31:16] : word[15:0];
    case (loadType)
      LD_W:    result = word;
      LD_H:    result = {{16{halfSel[15]}}, halfSel};
      LD_HU:   result = {16'h0000, halfSel};
      LD_B:    result = {{24{byteSel[7]}}, byteSel};
      LD_BU:   result = {24'h000000, byteSel};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/m_data_mem_unit.sv
// M-stage data memory with byte-lane stores and registered, extended loads into W.
// Optional write log enabled by defining DM_WRITE_LOG_EN.
module m_data_mem_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_Addr,
  input  logic        M_MemWrite,
  input  logic [1:0]  M_StoreType,
  input  logic        M_MemRead,
  input  logic [2:0]  M_LoadType,
  input  logic [31:0] M_TrueStoreData,
  output logic [3:0]  M_ByteEn,
  output logic        M_AlignErr,
  output logic [31:0] W_ReadData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           memArray [DEPTH];
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic                  misaligned;
  logic                  outOfRange;
  logic [31:0]           storeLanes;
  logic [31:0]           oldWord;
  logic [31:0]           mergedWord;
  logic [31:0]           loadResult;

  assign wordIdx    = M_Addr[ADDR_WIDTH+1:2];
  assign outOfRange = |M_Addr[31:ADDR_WIDTH+2];
  assign oldWord    = memArray[wordIdx];

  // Store and load sizes are checked independently so a combined access flags either fault.
  always_comb begin
    misaligned = 1'b0;
    if (M_MemWrite) begin
      case (M_StoreType)
        ST_W:    misaligned = misaligned | (|M_Addr[1:0]);
        ST_H:    misaligned = misaligned | M_Addr[0];
        default: misaligned = misaligned;
      endcase
    end
    if (M_MemRead) begin
      case (M_LoadType)
        LD_W:        misaligned = misaligned | (|M_Addr[1:0]);
        LD_H, LD_HU: misaligned = misaligned | M_Addr[0];
        default:     misaligned = misaligned;
      endcase
    end
  end

  assign M_AlignErr = (M_MemWrite | M_MemRead) & (misaligned | outOfRange);

  always_comb begin
    M_ByteEn   = 4'b0000;
    storeLanes = M_TrueStoreData;
    case (M_StoreType)
      ST_H:    storeLanes = {2{M_TrueStoreData[15:0]}};
      ST_B:    storeLanes = {4{M_TrueStoreData[7:0]}};
      default: storeLanes = M_TrueStoreData;
    endcase
    if (M_MemWrite && !M_AlignErr) begin
      case (M_StoreType)
        ST_W:    M_ByteEn = 4'b1111;
        ST_H:    M_ByteEn = M_Addr[1] ? 4'b1100 : 4'b0011;
        ST_B:    M_ByteEn = 4'b0001 << M_Addr[1:0];
        default: M_ByteEn = 4'b0000;
      endcase
    end
  end

  always_comb begin
    mergedWord = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (M_ByteEn[i]) mergedWord[8*i +: 8] = storeLanes[8*i +: 8];
    end
  end

  // Whole-word write of the merged value keeps untouched lanes intact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) memArray[i] <= 32'h0000_0000;
    end else if (|M_ByteEn) begin
      memArray[wordIdx] <= mergedWord;
    end
  end

  m_load_extender loadExt (
    .word     (oldWord),
    .addrLow  (M_Addr[1:0]),
    .loadType (M_LoadType),
    .result   (loadResult)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      W_ReadData <= 32'h0000_0000;
    end else if (M_MemRead && !M_AlignErr) begin
      W_ReadData <= loadResult;
    end else begin
      W_ReadData <= 32'h0000_0000;
    end
  end

`ifdef DM_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (reset && (|M_ByteEn)) begin
      $display("%d@%h: *%h <= %h", $time, M_PC, {M_Addr[31:2], 2'b00}, mergedWord);
    end
  end
`else
  logic unusedPc;
  assign unusedPc = ^M_PC;
`endif

endmodule

// File: tb/tb_m_data_mem_unit.sv
// Scoreboard bench for m_data_mem_unit: directed stores/loads, expectations queued per cycle.
module tb_m_data_mem_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mPc;
  logic [31:0] mAddr;
  logic        mMemWrite;
  logic [1:0]  mStoreType;
  logic        mMemRead;
  logic [2:0]  mLoadType;
  logic [31:0] mStoreData;
  logic [3:0]  mByteEn;
  logic        mAlignErr;
  logic [31:0] wReadData;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  int          dueQ[$];
  int          kindQ[$];
  logic [31:0] expQ[$];
  string       nameQ[$];

  localparam int K_READ  = 0;
  localparam int K_BYTEN = 1;
  localparam int K_ALIGN = 2;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  m_data_mem_unit #(.ADDR_WIDTH(12)) dut (
    .clk             (clk),
    .reset           (reset),
    .M_PC            (mPc),
    .M_Addr          (mAddr),
    .M_MemWrite      (mMemWrite),
    .M_StoreType     (mStoreType),
    .M_MemRead       (mMemRead),
    .M_LoadType      (mLoadType),
    .M_TrueStoreData (mStoreData),
    .M_ByteEn        (mByteEn),
    .M_AlignErr      (mAlignErr),
    .W_ReadData      (wReadData)
  );

  task automatic expectAt(input int offset, input int kind, input logic [31:0] value, input string name);
    dueQ.push_back(cycle + offset);
    kindQ.push_back(kind);
    expQ.push_back(value);
    nameQ.push_back(name);
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [1:0] st,
                               input logic rd, input logic [2:0] lt, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] pc);
    @(posedge clk);
    #1;
    reset      = rst;
    mMemWrite  = wr;
    mStoreType = st;
    mMemRead   = rd;
    mLoadType  = lt;
    mAddr      = addr;
    mStoreData = data;
    mPc        = pc;
  endtask

  task automatic doStore(input logic [1:0] st, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, st, 1'b0, LD_W, addr, data, 32'h0000_1000);
  endtask

  task automatic doLoad(input logic [2:0] lt, input logic [31:0] addr);
    applyStimulus(1'b1, 1'b0, ST_W, 1'b1, lt, addr, 32'h0, 32'h0000_1000);
  endtask

  task automatic doIdle();
    applyStimulus(1'b1, 1'b0, ST_W, 1'b0, LD_W, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input int kind, input logic [31:0] expected, input string name);
    logic [31:0] actual;
    case (kind)
      K_READ:  actual = wReadData;
      K_BYTEN: actual = {28'h0, mByteEn};
      default: actual = {31'h0, mAlignErr};
    endcase
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: pops every expectation due in the current cycle, sampled mid-cycle.
  always @(negedge clk) begin
    while (dueQ.size() > 0 && dueQ[0] <= cycle) begin
      if (dueQ[0] < cycle) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: check missed its cycle %0d (now %0d)", nameQ[0], dueQ[0], cycle);
      end else begin
        checkOutput(kindQ[0], expQ[0], nameQ[0]);
      end
      void'(dueQ.pop_front());
      void'(kindQ.pop_front());
      void'(expQ.pop_front());
      void'(nameQ.pop_front());
    end
  end

  initial begin
    reset = 1'b0; mMemWrite = 1'b0; mMemRead = 1'b0; mStoreType = ST_W;
    mLoadType = LD_W; mAddr = '0; mStoreData = '0; mPc = '0;

    applyStimulus(1'b0, 1'b0, ST_W, 1'b0, LD_W, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, ST_W, 1'b0, LD_W, 32'h0, 32'h0, 32'h0);
    expectAt(0, K_READ, 32'h0, "resetReadData");

    doLoad(LD_W, 32'h10);
    expectAt(0, K_ALIGN, 32'h0, "lwAfterResetAlign");
    expectAt(1, K_READ, 32'h0, "lwAfterResetData");

    doStore(ST_W, 32'h10, 32'hDEAD_BEEF);
    expectAt(0, K_BYTEN, 32'hF, "swByteEn");
    doLoad(LD_B, 32'h13);
    expectAt(1, K_READ, 32'hFFFF_FFDE, "lb13");
    doLoad(LD_BU, 32'h13);
    expectAt(1, K_READ, 32'h0000_00DE, "lbu13");
    doLoad(LD_H, 32'h12);
    expectAt(1, K_READ, 32'hFFFF_DEAD, "lh12");
    doLoad(LD_HU, 32'h10);
    expectAt(1, K_READ, 32'h0000_BEEF, "lhu10");
    doLoad(LD_B, 32'h10);
    expectAt(1, K_READ, 32'hFFFF_FFEF, "lb10");

    doStore(ST_B, 32'h21, 32'h1234_5678);
    expectAt(0, K_BYTEN, 32'h2, "sbByteEn");
    doStore(ST_H, 32'h22, 32'h0000_ABCD);
    expectAt(0, K_BYTEN, 32'hC, "shByteEn");
    doLoad(LD_W, 32'h20);
    expectAt(1, K_READ, 32'hABCD_7800, "lwMerged");

    doStore(ST_W, 32'h06, 32'h5555_5555);
    expectAt(0, K_ALIGN, 32'h1, "swMisalignErr");
    expectAt(0, K_BYTEN, 32'h0, "swMisalignByteEn");
    doLoad(LD_H, 32'h03);
    expectAt(0, K_ALIGN, 32'h1, "lhMisalignErr");
    expectAt(1, K_READ, 32'h0, "lhMisalignData");
    doStore(ST_W, 32'h0001_0000, 32'h7777_7777);
    expectAt(0, K_ALIGN, 32'h1, "swRangeErr");
    expectAt(0, K_BYTEN, 32'h0, "swRangeByteEn");
    doLoad(LD_W, 32'h04);
    expectAt(1, K_READ, 32'h0, "word1Unchanged");
    doLoad(LD_W, 32'h00);
    expectAt(1, K_READ, 32'h0, "word0NotAliased");
    doLoad(LD_W, 32'h0001_0010);
    expectAt(0, K_ALIGN, 32'h1, "lwRangeErr");
    expectAt(1, K_READ, 32'h0, "lwRangeData");
    doStore(ST_RSV, 32'h30, 32'h9999_9999);
    expectAt(0, K_BYTEN, 32'h0, "reservedStoreByteEn");
    doLoad(3'b101, 32'h10);
    expectAt(1, K_READ, 32'h0, "reservedLoadData");

    doStore(ST_W, 32'h40, 32'h1111_1111);
    applyStimulus(1'b0, 1'b1, ST_W, 1'b0, LD_W, 32'h40, 32'h2222_2222, 32'h0);
    doLoad(LD_W, 32'h40);
    expectAt(1, K_READ, 32'h0, "lwAfterResetClear");
    doLoad(LD_W, 32'h10);
    expectAt(1, K_READ, 32'h0, "resetClearedWord4");

    doStore(ST_W, 32'h50, 32'h0102_0304);
    applyStimulus(1'b1, 1'b1, ST_W, 1'b1, LD_W, 32'h50, 32'hFFFF_FFFF, 32'h0);
    expectAt(1, K_READ, 32'h0102_0304, "sameCycleOldData");
    doLoad(LD_W, 32'h50);
    expectAt(1, K_READ, 32'hFFFF_FFFF, "afterSameCycleWrite");

    applyStimulus(1'b1, 1'b1, ST_W, 1'b0, LD_W, 32'h44, 32'hCAFE_F00D, 32'h0000_3008);
    expectAt(0, K_BYTEN, 32'hF, "loggedSwByteEn");
    doLoad(LD_W, 32'h44);
    expectAt(1, K_READ, 32'hCAFE_F00D, "loggedSwData");
    doIdle();
    expectAt(0, K_ALIGN, 32'h0, "idleNoAlignErr");

    repeat (3) doIdle();
    while (dueQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: expectation never checked", nameQ[0]);
      void'(dueQ.pop_front());
      void'(kindQ.pop_front());
      void'(expQ.pop_front());
      void'(nameQ.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
